// File: rtl/quidditch_pkg.sv
// rtl/quidditch_pkg.sv - Shared match state, winner codes and default constants.
package quidditch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } match_state_t;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    BLUE = 2'b01,
    RED  = 2'b10,
    DRAW = 2'b11
  } winner_t;

  localparam int unsigned DEFAULT_WIN_SCORE    = 5;
  localparam int unsigned DEFAULT_SERVE_CYCLES = 50_000_000;

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - 1-bit rising-edge detector with a parameterised previous-value reset.
module rise_detect #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (!rst_n) prev <= RESET_VAL;
    else        prev <= din;
  end

  assign rise = din & ~prev;

endmodule

// File: rtl/match_sequencer.sv
// rtl/match_sequencer.sv - Quidditch match FSM with scoring and serve delay; MATCH_TIMER_EN adds the match clock.
module match_sequencer
  import quidditch_pkg::*;
#(
  parameter int unsigned WIN_SCORE     = DEFAULT_WIN_SCORE,
  parameter int unsigned SERVE_CYCLES  = DEFAULT_SERVE_CYCLES,
  parameter int unsigned CLK_HZ        = 50_000_000,
  parameter int unsigned MATCH_SECONDS = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_btn,
  input  logic       blue_score_up,
  input  logic       red_score_up,
  output logic       game_initiated,
  output logic       game_over,
  output logic [1:0] match_state,
  output logic [3:0] blue_score,
  output logic [3:0] red_score,
  output logic [1:0] winner,
  output logic [7:0] time_left
);

  localparam logic [3:0]  WIN_VAL    = 4'(WIN_SCORE);
  localparam logic [31:0] SERVE_LAST = 32'(SERVE_CYCLES - 1);

  match_state_t state;
  logic [31:0]  serve_cnt;
  logic         start_rise, blue_rise, red_rise;
  logic [3:0]   blue_next, red_next;
  logic         blue_wins, red_wins;

  // Start detector presets high so a button held through reset is not a start.
  rise_detect #(.RESET_VAL(1'b1)) u_start_rise (
    .clk(clk), .rst_n(rst_n), .din(start_btn), .rise(start_rise)
  );
  rise_detect #(.RESET_VAL(1'b0)) u_blue_rise (
    .clk(clk), .rst_n(rst_n), .din(blue_score_up), .rise(blue_rise)
  );
  rise_detect #(.RESET_VAL(1'b0)) u_red_rise (
    .clk(clk), .rst_n(rst_n), .din(red_score_up), .rise(red_rise)
  );

  assign blue_next   = blue_score + 4'(blue_rise);
  assign red_next    = red_score + 4'(red_rise);
  assign blue_wins   = (blue_next == WIN_VAL);
  assign red_wins    = (red_next == WIN_VAL);
  assign match_state = state;

`ifdef MATCH_TIMER_EN
  localparam logic [31:0] PRESC_LAST  = 32'(CLK_HZ - 1);
  localparam logic [7:0]  TIME_RELOAD = 8'(MATCH_SECONDS);

  logic [31:0] presc;
  logic [7:0]  time_cnt;
  logic        sec_wrap, time_up;
  winner_t     leader;

  assign sec_wrap  = (presc == PRESC_LAST);
  assign time_up   = sec_wrap && (time_cnt == 8'd1);
  assign time_left = time_cnt;
  assign leader    = (blue_next > red_next) ? BLUE :
                     (red_next > blue_next) ? RED : DRAW;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc    <= '0;
      time_cnt <= TIME_RELOAD;
    end else if ((state == IDLE || state == OVER) && start_rise) begin
      presc    <= '0;
      time_cnt <= TIME_RELOAD;
    end else if (state == PLAY) begin
      if (sec_wrap) begin
        presc <= '0;
        if (time_cnt != 8'd0) time_cnt <= time_cnt - 8'd1;
      end else begin
        presc <= presc + 32'd1;
      end
    end
  end
`else
  // Timer parameters stay on the interface in both builds; untimed builds read zero.
  assign time_left = 8'(MATCH_SECONDS) & 8'(CLK_HZ) & 8'h00;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      serve_cnt      <= '0;
      blue_score     <= '0;
      red_score      <= '0;
      winner         <= NONE;
      game_initiated <= 1'b0;
      game_over      <= 1'b0;
    end else begin
      case (state)
        IDLE, OVER: begin
          if (start_rise) begin
            state      <= SERVE;
            serve_cnt  <= '0;
            blue_score <= '0;
            red_score  <= '0;
            winner     <= NONE;
            game_over  <= 1'b0;
          end
        end
        SERVE: begin
          if (serve_cnt == SERVE_LAST) begin
            state          <= PLAY;
            game_initiated <= 1'b1;
          end else begin
            serve_cnt <= serve_cnt + 32'd1;
          end
        end
        PLAY: begin
          blue_score <= blue_next;
          red_score  <= red_next;
          // A winning goal outranks timer expiry when deciding the winner.
          if (blue_wins || red_wins) begin
            state          <= OVER;
            game_initiated <= 1'b0;
            game_over      <= 1'b1;
            winner         <= (blue_wins && red_wins) ? DRAW : (blue_wins ? BLUE : RED);
          end
`ifdef MATCH_TIMER_EN
          else if (time_up) begin
            state          <= OVER;
            game_initiated <= 1'b0;
            game_over      <= 1'b1;
            winner         <= leader;
          end
`endif
          else if (blue_rise || red_rise) begin
            state          <= SERVE;
            serve_cnt      <= '0;
            game_initiated <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_match_sequencer.sv
// tb/tb_match_sequencer.sv - Randomised scenario bench for match_sequencer against a goal-level match model.
module tb_match_sequencer;

  localparam int S    = 4;
  localparam int WIN  = 3;
  localparam int CHZ  = 10;
  localparam int MSEC = 2;
`ifdef MATCH_TIMER_EN
  localparam int TL_RESET = MSEC;
`else
  localparam int TL_RESET = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_btn = 1'b0;
  logic       blue_score_up = 1'b0;
  logic       red_score_up = 1'b0;
  logic       game_initiated, game_over;
  logic [1:0] match_state, winner;
  logic [3:0] blue_score, red_score;
  logic [7:0] time_left;
  logic [13:0] obs;

  int vectors = 0;
  int errors  = 0;
  int m_state = 0, m_blue = 0, m_red = 0, m_winner = 0;

  match_sequencer #(
    .WIN_SCORE(WIN), .SERVE_CYCLES(S), .CLK_HZ(CHZ), .MATCH_SECONDS(MSEC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_btn(start_btn),
    .blue_score_up(blue_score_up), .red_score_up(red_score_up),
    .game_initiated(game_initiated), .game_over(game_over),
    .match_state(match_state), .blue_score(blue_score), .red_score(red_score),
    .winner(winner), .time_left(time_left)
  );

  always #5 clk = ~clk;

  assign obs = {match_state, blue_score, red_score, winner, game_initiated, game_over};

  function automatic logic [13:0] model_pack();
    return {2'(m_state), 4'(m_blue), 4'(m_red), 2'(m_winner), m_state == 2, m_state == 3};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Stimulus: one start edge from IDLE/OVER; the model starts a fresh match.
  task automatic start_pulse();
    start_btn = 1'b1;
    tick(1);
    start_btn = 1'b0;
    m_state = 1; m_blue = 0; m_red = 0; m_winner = 0;
  endtask

  // Stimulus: one goal cycle in PLAY; the model applies the scoring rules.
  task automatic goal(input bit b, input bit r);
    blue_score_up = b;
    red_score_up  = r;
    tick(1);
    blue_score_up = 1'b0;
    red_score_up  = 1'b0;
    m_blue += int'(b);
    m_red  += int'(r);
    if (m_blue == WIN || m_red == WIN) begin
      m_state  = 3;
      m_winner = (m_blue == WIN && m_red == WIN) ? 3 : (m_blue == WIN ? 1 : 2);
    end else begin
      m_state = 1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_btn = 1'b1; blue_score_up = 1'b1;
    tick(2);
    vectors++;
    if ({obs, time_left} !== {model_pack(), 8'(TL_RESET)}) begin
      errors++;
      $display("FAIL reset_values: observed %h/%0d required %h/%0d", obs, time_left, model_pack(), TL_RESET);
    end
    rst_n = 1'b1;
    tick(3);
    vectors++;
    if (obs !== model_pack()) begin
      errors++;
      $display("FAIL held_start_no_edge: observed %h required %h", obs, model_pack());
    end
    start_btn = 1'b0; blue_score_up = 1'b0;
    tick(1);
  endtask

  task automatic test_start();
    tick(5);
    start_pulse();
    vectors++;
    if (obs !== model_pack()) begin
      errors++;
      $display("FAIL start_to_serve: observed %h required %h", obs, model_pack());
    end
    tick(S - 1);
    vectors++;
    if (game_initiated !== 1'b0 || match_state !== 2'd1) begin
      errors++;
      $display("FAIL serve_last_cycle: observed gi=%0b st=%0d required gi=0 st=1", game_initiated, match_state);
    end
    tick(1);
    m_state = 2;
    vectors++;
    if (obs !== model_pack()) begin
      errors++;
      $display("FAIL serve_to_play: observed %h required %h", obs, model_pack());
    end
  endtask

  task automatic test_blue_wins();
    for (int i = 0; i < 3; i++) begin
      tick($urandom_range(0, 3));
      goal(1'b1, 1'b0);
      vectors++;
      if (obs !== model_pack()) begin
        errors++;
        $display("FAIL blue_goal_%0d: observed %h required %h", i, obs, model_pack());
      end
      if (m_state == 1) begin
        tick(S);
        m_state = 2;
        vectors++;
        if (obs !== model_pack()) begin
          errors++;
          $display("FAIL blue_serve_%0d: observed %h required %h", i, obs, model_pack());
        end
      end
    end
  endtask

  task automatic test_over_hold();
    for (int i = 0; i < 3; i++) begin
      int unsigned kind;
      kind = $urandom_range(1, 3);
      blue_score_up = kind[0]; red_score_up = kind[1];
      tick(1);
      blue_score_up = 1'b0; red_score_up = 1'b0;
      tick($urandom_range(1, 2));
      vectors++;
      if (obs !== model_pack()) begin
        errors++;
        $display("FAIL over_hold_%0d: observed %h required %h", i, obs, model_pack());
      end
    end
  endtask

  task automatic test_serve_ignore();
    start_pulse();
    vectors++;
    if (obs !== model_pack()) begin
      errors++;
      $display("FAIL rematch_clears: observed %h required %h", obs, model_pack());
    end
    for (int j = 0; j < S - 1; j++) begin
      int unsigned kind;
      kind = $urandom_range(1, 7);
      start_btn = kind[0]; blue_score_up = kind[1]; red_score_up = kind[2];
      tick(1);
      start_btn = 1'b0; blue_score_up = 1'b0; red_score_up = 1'b0;
      vectors++;
      if (obs !== model_pack()) begin
        errors++;
        $display("FAIL serve_ignore_%0d: observed %h required %h", j, obs, model_pack());
      end
    end
    tick(1);
    m_state = 2;
    vectors++;
    if (obs !== model_pack()) begin
      errors++;
      $display("FAIL serve_ignore_exit: observed %h required %h", obs, model_pack());
    end
  endtask

  task automatic test_play_start();
    for (int i = 0; i < 2; i++) begin
      start_btn = 1'b1;
      tick(1);
      start_btn = 1'b0;
      tick(1);
      vectors++;
      if (obs !== model_pack()) begin
        errors++;
        $display("FAIL play_start_%0d: observed %h required %h", i, obs, model_pack());
      end
    end
  endtask

  task automatic test_draw();
    int need_b, need_r;
    need_b = (WIN - 1) - m_blue;
    need_r = (WIN - 1) - m_red;
    while (need_b + need_r > 0) begin
      bit pick_blue;
      pick_blue = (need_r == 0) || (need_b > 0 && $urandom_range(0, 1) == 1);
      if (pick_blue) need_b--; else need_r--;
      goal(pick_blue, !pick_blue);
      tick(S);
      m_state = 2;
      vectors++;
      if (obs !== model_pack()) begin
        errors++;
        $display("FAIL draw_setup: observed %h required %h", obs, model_pack());
      end
    end
    goal(1'b1, 1'b1);
    vectors++;
    if (obs !== model_pack()) begin
      errors++;
      $display("FAIL draw_simultaneous: observed %h required %h", obs, model_pack());
    end
  endtask

  task automatic test_random_matches();
    for (int k = 0; k < 4; k++) begin
      start_pulse();
      tick(S);
      m_state = 2;
      while (m_state == 2) begin
        int unsigned kind;
        tick($urandom_range(0, 2));
        kind = $urandom_range(1, 3);
        goal(kind[0], kind[1]);
        vectors++;
        if (obs !== model_pack()) begin
          errors++;
          $display("FAIL random_goal_m%0d: observed %h required %h", k, obs, model_pack());
        end
        if (m_state == 1) begin
          tick(S);
          m_state = 2;
        end
      end
    end
  endtask

  task automatic test_reset_mid_play();
    start_pulse();
    tick(S);
    m_state = 2;
    for (int i = 0; i < 3; i++) begin
      goal(i != 1, i == 1);
      tick(S);
      m_state = 2;
    end
    vectors++;
    if (obs !== model_pack()) begin
      errors++;
      $display("FAIL pre_reset_2_1: observed %h required %h", obs, model_pack());
    end
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    m_state = 0; m_blue = 0; m_red = 0; m_winner = 0;
    vectors++;
    if (obs !== model_pack()) begin
      errors++;
      $display("FAIL mid_play_reset: observed %h required %h", obs, model_pack());
    end
  endtask

  task automatic test_held_blue();
    tick(1);
    start_pulse();
    tick(S);
    m_state = 2;
    blue_score_up = 1'b1;
    tick(20);
    blue_score_up = 1'b0;
    m_blue = 1;
    vectors++;
    if (obs !== model_pack()) begin
      errors++;
      $display("FAIL held_blue_once: observed %h required %h", obs, model_pack());
    end
  endtask

`ifdef MATCH_TIMER_EN
  task automatic test_timer();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    start_pulse();
    tick(S);
    m_state = 2;
    goal(1'b1, 1'b0);
    tick(S);
    m_state = 2;
    tick(8);
    vectors++;
    if (time_left !== 8'(MSEC)) begin
      errors++;
      $display("FAIL timer_9_cycles: observed %0d required %0d", time_left, MSEC);
    end
    tick(1);
    vectors++;
    if (time_left !== 8'(MSEC - 1) || obs !== model_pack()) begin
      errors++;
      $display("FAIL timer_10_cycles: observed %0d/%h required %0d/%h", time_left, obs, MSEC - 1, model_pack());
    end
    tick(10);
    m_state = 3; m_winner = 1;
    vectors++;
    if (time_left !== 8'd0 || obs !== model_pack()) begin
      errors++;
      $display("FAIL timer_expiry: observed %0d/%h required 0/%h", time_left, obs, model_pack());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_start();
    test_blue_wins();
    test_over_hold();
    test_serve_ignore();
    test_play_start();
    test_draw();
    test_random_matches();
    test_reset_mid_play();
    test_held_blue();
`ifdef MATCH_TIMER_EN
    test_timer();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
